// File: rtl/sprite_motion_ctrl_pkg.sv
// Shared types, default screen/sprite geometry and the single-axis move helper
// used by the sprite motion scheduler.
package sprite_motion_pkg;

  localparam int DEF_SCREEN_W  = 480;
  localparam int DEF_SCREEN_H  = 272;
  localparam int DEF_SPRITE_W  = 50;
  localparam int DEF_SPRITE_H  = 100;
  localparam int DEF_STEP      = 2;
  localparam int DEF_HIT_TICKS = 15;

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_RUN   = 2'd1,
    ST_HIT   = 2'd2
  } state_e;

  typedef enum logic {
    DIR_POS = 1'b0,  // right / down
    DIR_NEG = 1'b1   // left / up
  } dir_e;

  typedef struct packed {
    logic [9:0] pos;
    dir_e       dir;
    logic       bounce;
  } axis_t;

  function automatic dir_e dir_flip(dir_e d);
    return (d == DIR_POS) ? DIR_NEG : DIR_POS;
  endfunction

  // One step along an axis, clamping at 0 or lim and flipping direction on contact.
  function automatic axis_t axis_step(logic [9:0] pos, dir_e dir, logic [9:0] step,
                                      logic [9:0] lim);
    axis_t      r;
    logic [9:0] nx;
    r.pos    = pos;
    r.dir    = dir;
    r.bounce = 1'b0;
    nx       = pos + step;
    if (dir == DIR_POS) begin
      if (nx >= lim) begin
        r.pos    = lim;
        r.dir    = DIR_NEG;
        r.bounce = 1'b1;
      end else begin
        r.pos = nx;
      end
    end else begin
      if (pos <= step) begin
        r.pos    = '0;
        r.dir    = DIR_POS;
        r.bounce = 1'b1;
      end else begin
        r.pos = pos - step;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// Strobe/key/raster inputs and sprite state outputs of the motion scheduler.
interface sprite_motion_ctrl_if;
  logic       tick;
  logic [2:0] key;
  logic [8:0] x;
  logic [8:0] y;
  logic [8:0] sprite_x;
  logic [8:0] sprite_y;
  logic [7:0] bounce_cnt;
  logic       hit;
  logic       running;

  modport master (
    output tick, key, x, y,
    input  sprite_x, sprite_y, bounce_cnt, hit, running
  );

  modport slave (
    input  tick, key, x, y,
    output sprite_x, sprite_y, bounce_cnt, hit, running
  );
endinterface

// File: rtl/sprite_motion_ctrl_key_edge.sv
// Registered rising-edge detector: a pulse appears one cycle after the input rises.
module key_edge_detect #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] rise_q, rise_d;

  always_comb begin
    prev_d = din;
    rise_d = din & ~prev_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q <= '0;
      rise_q <= '0;
    end else begin
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Sprite motion scheduler: PAUSE/RUN/HIT FSM, position/direction, bounce count, hit flash.
// Define SPRITE_MOTION_CTRL_TEAR_FREE_EN to defer each move into vertical blanking.
module sprite_motion_ctrl
  import sprite_motion_pkg::*;
#(
  parameter int SCREEN_W  = DEF_SCREEN_W,
  parameter int SCREEN_H  = DEF_SCREEN_H,
  parameter int SPRITE_W  = DEF_SPRITE_W,
  parameter int SPRITE_H  = DEF_SPRITE_H,
  parameter int STEP      = DEF_STEP,
  parameter int HIT_TICKS = DEF_HIT_TICKS
) (
  input logic                 clock,
  input logic                 reset,
  sprite_motion_ctrl_if.slave bus
);

  localparam logic [9:0] X_LIM  = 10'(SCREEN_W - SPRITE_W);
  localparam logic [9:0] Y_LIM  = 10'(SCREEN_H - SPRITE_H);
  localparam logic [9:0] X_RST  = 10'((SCREEN_W - SPRITE_W) / 2);
  localparam logic [9:0] Y_RST  = 10'((SCREEN_H - SPRITE_H) / 2);
  localparam logic [9:0] STEP_N = 10'(STEP);
  localparam logic [9:0] STEP_F = 10'(2 * STEP);
  localparam int         HCW    = (HIT_TICKS > 1) ? $clog2(HIT_TICKS) : 1;
  localparam logic [HCW-1:0] HIT_LAST = HCW'(HIT_TICKS - 1);

  // Bit 0 is run/pause, bit 1 is reverse-x; fast (key[1]) is level-sensitive.
  logic [1:0] key_rise;

  key_edge_detect #(.WIDTH(2)) u_key_edge (
    .clock (clock),
    .reset (reset),
    .din   ({bus.key[2], bus.key[0]}),
    .rise  (key_rise)
  );

  state_e         state_q, state_d;
  logic [9:0]     sx_q, sx_d, sy_q, sy_d;
  dir_e           dx_q, dx_d, dy_q, dy_d;
  logic [7:0]     bounce_q, bounce_d;
  logic [HCW-1:0] hit_cnt_q, hit_cnt_d;
  logic           pending_q, pending_d;
  logic           hit_q, hit_d;
  logic           running_q, running_d;

  dir_e       dx_eff;
  logic [9:0] step;
  logic       move_req;
  axis_t      ax, ay;

  always_comb begin
    state_d   = state_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    dy_d      = dy_q;
    bounce_d  = bounce_q;
    hit_cnt_d = hit_cnt_q;
    pending_d = pending_q;

    // A reverse edge takes effect before any move in the same cycle.
    dx_eff = key_rise[1] ? dir_flip(dx_q) : dx_q;
    dx_d   = dx_eff;
    step   = bus.key[1] ? STEP_F : STEP_N;
    ax     = axis_step(sx_q, dx_eff, step, X_LIM);
    ay     = axis_step(sy_q, dy_q, step, Y_LIM);
`ifdef SPRITE_MOTION_CTRL_TEAR_FREE_EN
    move_req = pending_q && ({1'b0, bus.y} >= 10'(SCREEN_H));
`else
    move_req = bus.tick;
`endif

    unique case (state_q)
      ST_PAUSE: begin
        if (key_rise[0]) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (key_rise[0]) begin
          state_d   = ST_PAUSE;
          pending_d = 1'b0;
        end else begin
          if (move_req) begin
            sx_d      = ax.pos;
            dx_d      = ax.dir;
            sy_d      = ay.pos;
            dy_d      = ay.dir;
            bounce_d  = bounce_q + 8'(ax.bounce) + 8'(ay.bounce);
            pending_d = 1'b0;
            if (ax.bounce || ay.bounce) begin
              state_d   = ST_HIT;
              hit_cnt_d = '0;
            end
          end
          if (bus.tick && (state_d == ST_RUN)) pending_d = 1'b1;
        end
      end
      ST_HIT: begin
        if (key_rise[0]) begin
          state_d   = ST_PAUSE;
          hit_cnt_d = '0;
        end else if (bus.tick) begin
          if (hit_cnt_q == HIT_LAST) begin
            state_d   = ST_RUN;
            hit_cnt_d = '0;
          end else begin
            hit_cnt_d = hit_cnt_q + HCW'(1);
          end
        end
      end
      default: state_d = ST_PAUSE;
    endcase

`ifndef SPRITE_MOTION_CTRL_TEAR_FREE_EN
    pending_d = 1'b0;  // every RUN tick moves directly; nothing is ever deferred
`endif
    hit_d     = (state_d == ST_HIT);
    running_d = (state_d != ST_PAUSE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_PAUSE;
      sx_q      <= X_RST;
      sy_q      <= Y_RST;
      dx_q      <= DIR_POS;
      dy_q      <= DIR_POS;
      bounce_q  <= '0;
      hit_cnt_q <= '0;
      pending_q <= 1'b0;
      hit_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      bounce_q  <= bounce_d;
      hit_cnt_q <= hit_cnt_d;
      pending_q <= pending_d;
      hit_q     <= hit_d;
      running_q <= running_d;
    end
  end

  assign bus.sprite_x   = sx_q[8:0];
  assign bus.sprite_y   = sy_q[8:0];
  assign bus.bounce_cnt = bounce_q;
  assign bus.hit        = hit_q;
  assign bus.running    = running_q;

  logic unused_sig;
`ifdef SPRITE_MOTION_CTRL_TEAR_FREE_EN
  assign unused_sig = ^{bus.x, sx_q[9], sy_q[9]};
`else
  assign unused_sig = ^{bus.x, bus.y, pending_q, sx_q[9], sy_q[9]};
`endif

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench for sprite_motion_ctrl: directed scenarios plus random
// stimulus compared every cycle against an integer reference model.
module tb_sprite_motion_ctrl;

  localparam int X_LIM     = 430;
  localparam int Y_LIM     = 172;
  localparam int BLANK_Y   = 272;
  localparam int HIT_TICKS = 15;

  logic clock = 1'b0;
  logic reset = 1'b0;

  sprite_motion_ctrl_if bus ();

  sprite_motion_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: 0 = paused, 1 = running, 2 = flashing; directions are +1/-1.
  int m_state, m_x, m_y, m_dx, m_dy, m_bounce, m_hcnt, m_pend;
  logic [2:0] k_hist1, k_hist2;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_state = 0; m_x = 215; m_y = 86; m_dx = 1; m_dy = 1;
    m_bounce = 0; m_hcnt = 0; m_pend = 0;
    k_hist1 = '0; k_hist2 = '0;
  endtask

  task automatic model_step(input bit tick, input logic [2:0] key, input int y);
    bit e0, e2, want;
    int stp, nx, ny, bx, by;
    e0 = k_hist1[0] & ~k_hist2[0];
    e2 = k_hist1[2] & ~k_hist2[2];
    if (e2) m_dx = -m_dx;
`ifdef SPRITE_MOTION_CTRL_TEAR_FREE_EN
    want = (m_pend != 0) && (y >= BLANK_Y);
`else
    want = tick;
`endif
    case (m_state)
      0: if (e0) m_state = 1;
      1: begin
        if (e0) begin
          m_state = 0;
          m_pend  = 0;
        end else begin
          if (want) begin
            stp = key[1] ? 4 : 2;
            bx = 0; by = 0;
            nx = m_x + m_dx * stp;
            if (nx >= X_LIM) begin nx = X_LIM; m_dx = -1; bx = 1; end
            else if (nx <= 0) begin nx = 0; m_dx = 1; bx = 1; end
            ny = m_y + m_dy * stp;
            if (ny >= Y_LIM) begin ny = Y_LIM; m_dy = -1; by = 1; end
            else if (ny <= 0) begin ny = 0; m_dy = 1; by = 1; end
            m_x = nx; m_y = ny;
            m_bounce = (m_bounce + bx + by) % 256;
            m_pend = 0;
            if (bx + by > 0) begin m_state = 2; m_hcnt = 0; end
          end
`ifdef SPRITE_MOTION_CTRL_TEAR_FREE_EN
          if (tick && m_state == 1) m_pend = 1;
`endif
        end
      end
      default: begin
        if (e0) begin
          m_state = 0;
          m_hcnt  = 0;
        end else if (tick) begin
          m_hcnt++;
          if (m_hcnt == HIT_TICKS) begin m_state = 1; m_hcnt = 0; end
        end
      end
    endcase
    k_hist2 = k_hist1;
    k_hist1 = key;
  endtask

  task automatic compare_all();
    check_val("sprite_x", int'(bus.sprite_x), m_x);
    check_val("sprite_y", int'(bus.sprite_y), m_y);
    check_val("bounce_cnt", int'(bus.bounce_cnt), m_bounce);
    check_val("hit", int'(bus.hit), (m_state == 2) ? 1 : 0);
    check_val("running", int'(bus.running), (m_state != 0) ? 1 : 0);
  endtask

  // Called at a falling edge: drive one cycle of inputs, advance the model, sample next falling edge.
  task automatic step(input bit tick, input logic [2:0] key, input int y);
    bus.tick = tick;
    bus.key  = key;
    bus.y    = 9'(y);
    bus.x    = 9'($urandom_range(0, 479));
    model_step(tick, key, y);
    @(negedge clock);
    compare_all();
  endtask

  task automatic async_reset();
    reset    = 1'b0;
    bus.tick = 1'b0;
    bus.key  = '0;
    #1;
    model_reset();
    compare_all();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic start_run();
    step(1'b0, 3'b001, 0);
    step(1'b0, 3'b000, 0);
    check_val("start_running", int'(bus.running), 1);
  endtask

  initial begin
    logic [2:0] key_lvl;
    int prev_b, wrap_seen, hit_run, hit_len_done, cyc, yv;

    bus.tick = 1'b0; bus.key = '0; bus.x = '0; bus.y = '0;
    model_reset();
    repeat (3) @(negedge clock);
    compare_all();
    check_val("rst_x", int'(bus.sprite_x), 215);
    check_val("rst_y", int'(bus.sprite_y), 86);
    check_val("rst_running", int'(bus.running), 0);
    reset = 1'b1;

    start_run();
    $display("txn start: running=%0d x=%0d y=%0d", bus.running, bus.sprite_x, bus.sprite_y);

`ifndef SPRITE_MOTION_CTRL_TEAR_FREE_EN
    step(1'b1, 3'b000, 0);
    check_val("single_x", int'(bus.sprite_x), 217);
    check_val("single_y", int'(bus.sprite_y), 88);
    step(1'b1, 3'b010, 0);
    check_val("fast_x", int'(bus.sprite_x), 221);
    check_val("fast_y", int'(bus.sprite_y), 92);
    step(1'b0, 3'b100, 0);
    step(1'b1, 3'b000, 0);
    check_val("rev_x", int'(bus.sprite_x), 219);
    check_val("rev_y", int'(bus.sprite_y), 94);
    step(1'b0, 3'b001, 0);
    step(1'b1, 3'b000, 0);
    check_val("conflict_x", int'(bus.sprite_x), 219);
    check_val("conflict_run", int'(bus.running), 0);
    $display("txn directed moves: x=%0d y=%0d", bus.sprite_x, bus.sprite_y);
`else
    repeat (3) step(1'b1, 3'b000, 100);
    check_val("defer_hold_x", int'(bus.sprite_x), 215);
    check_val("defer_hold_y", int'(bus.sprite_y), 86);
    step(1'b0, 3'b000, BLANK_Y);
    check_val("defer_apply_x", int'(bus.sprite_x), 217);
    check_val("defer_apply_y", int'(bus.sprite_y), 88);
    step(1'b0, 3'b000, BLANK_Y);
    check_val("defer_once_x", int'(bus.sprite_x), 217);
    $display("txn deferral: x=%0d y=%0d", bus.sprite_x, bus.sprite_y);
`endif

    key_lvl = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 15) == 0) key_lvl[b] = ~key_lvl[b];
      yv = $urandom_range(0, 299);
      if (i == 1500) begin
        async_reset();
        key_lvl = '0;
        $display("txn async reset at random cycle %0d", i);
      end
      step(1'(($urandom_range(0, 1))), key_lvl, yv);
    end
    $display("txn random phase: bounce_cnt=%0d", bus.bounce_cnt);

    // Continuous fast motion until the bounce counter wraps past 255.
    async_reset();
    start_run();
    prev_b = 0; wrap_seen = 0; hit_run = 0; hit_len_done = 0; cyc = 0;
    while (wrap_seen == 0 && cyc < 30000) begin
      step(1'b1, 3'b010, 300);
      cyc++;
      if (int'(bus.bounce_cnt) < prev_b) wrap_seen = 1;
      prev_b = int'(bus.bounce_cnt);
      if (bus.hit) hit_run++;
      else begin
        if (hit_run > 0 && hit_len_done == 0) begin
          check_val("hit_len", hit_run, HIT_TICKS);
          hit_len_done = 1;
        end
        hit_run = 0;
      end
    end
    check_val("bounce_wrap", wrap_seen, 1);
    check_val("hit_len_seen", hit_len_done, 1);
    $display("txn wrap phase: cycles=%0d bounce_cnt=%0d", cyc, bus.bounce_cnt);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sprite_motion_ctrl.md
# sprite_motion_ctrl

Motion scheduler for the rectangle sprite on the 480×272 LCD. It consumes the strobe from `strobe_gen` and key presses, and owns the sprite position, direction, bounce count and hit-flash state. It schedules each position step so it lands in vertical blanking, so the pixel-colour logic never sees a half-moved sprite. Its outputs feed the pixel comparator, the LEDs and the seven-segment display.

## Interface

- `SCREEN_W`, 480: visible width in pixels.
- `SCREEN_H`, 272: visible height in pixels.
- `SPRITE_W`, 50: sprite width.
- `SPRITE_H`, 100: sprite height.
- `STEP`, 2: pixels per move at normal speed.
- `HIT_TICKS`, 15: ticks the hit flash lasts.
- `clock` in 1: single clock.
- `reset` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle strobe from `strobe_gen`.
- `key` in 3: [0] run/pause, [1] fast while held, [2] reverse x. Synchronous to `clock` (synchronised upstream).
- `x` in 9: current LCD pixel column.
- `y` in 9: current LCD pixel row.
- `sprite_x` out 9: sprite left edge.
- `sprite_y` out 9: sprite top edge.
- `bounce_cnt` out 8: number of wall contacts, modulo 256.
- `hit` out 1: high while the flash is active.
- `running` out 1: high in RUN or HIT.

## Operation

- **States:** PAUSE, RUN, HIT.
- **Reset values:**
  - state = PAUSE.
  - `sprite_x` = (SCREEN_W−SPRITE_W)/2 = 215; `sprite_y` = (SCREEN_H−SPRITE_H)/2 = 86.
  - Directions: right, down.
  - `bounce_cnt` = 0, `hit` = 0, `running` = 0, pending = 0, hit counter = 0.
- **Key handling:** rising edges of `key[0]` and `key[2]` are detected against a registered copy of `key`. `key[1]` is level-sensitive.
- **State transitions:**
  - PAUSE → RUN on a `key[0]` edge.
  - RUN → PAUSE on a `key[0]` edge.
  - RUN → HIT when a move causes a bounce.
  - HIT → RUN after HIT_TICKS ticks.
  - HIT → PAUSE on a `key[0]` edge; clears `hit` and the hit counter.
- **Pending move:**
  - In RUN, `tick` sets pending.
  - Multiple ticks before the move is applied coalesce into one move.
  - In PAUSE and HIT, `tick` never sets pending; pending is cleared on entering PAUSE.
- **Step size:** `key[1]` high means 2·STEP, otherwise STEP. It is sampled at the moment the move is applied.
- **Move arithmetic:** computed in 10 bits.
  - Right: nx = sprite_x + step. If nx ≥ SCREEN_W−SPRITE_W, clamp to SCREEN_W−SPRITE_W, flip to left, bounce.
  - Left: if sprite_x ≤ step, clamp to 0, flip to right, bounce.
  - y axis: same rules using SCREEN_H−SPRITE_H.
- **Bounce:** `bounce_cnt` += 1 per bouncing axis, so a corner adds 2. It wraps from 255 to 0. Any bounce enters HIT with `hit` = 1 and the hit counter = 0.
- **In HIT:** no motion. Each tick increments the hit counter; at HIT_TICKS−1 the block returns to RUN with `hit` = 0.
- **Reverse key:** a `key[2]` edge in any state flips the x direction. If it coincides with an applied move, the flip is applied first and the move uses the new direction.
- **Simultaneous key[0] edge and applied move:** the key wins; no move is made and the block enters PAUSE.

## Timing

- All outputs are registered.
- Key edge: key rises at cycle t, the edge is detected at t+1, the state/output changes at t+2.
- Move without the macro: tick at t, position updates at t+1.
- Move with the macro: the move applies on the first cycle at or after the cycle following the tick where `y` ≥ SCREEN_H. Outputs change the next cycle.
- Blanking that is already in progress at the tick still qualifies.
- Asserting reset mid-move discards pending and restores all reset values immediately (asynchronous).

## Configuration

- **`SPRITE_MOTION_CTRL_TEAR_FREE_EN`**
  - Defined: moves are deferred to vertical blanking (`y` ≥ SCREEN_H), as described in Timing.
  - Undefined: pending is bypassed, `x`/`y` are unused, and each RUN tick moves the sprite on the next cycle.

## Structure

- **Package `sprite_motion_pkg`:** state enum (PAUSE, RUN, HIT), default screen and sprite constants, direction typedef.
- **Sub-module `key_edge_detect`:** parameterised width, async active-low reset; outputs one-cycle rising-edge pulses.
- **Top level:** FSM, pending flag, hit counter, position/direction registers, bounce counter.

## Test plan

- **Reset, then start:** reset low → 215/86, `running` = 0. `key[0]` pulse → `running` = 1 two cycles later.
- **Single and fast steps:** RUN, one tick (macro off) → `sprite_x` = 217, `sprite_y` = 88 next cycle. Same with `key[1]` held → 219/90.
- **Right-wall bounce:** `sprite_x` = 428, direction right, tick → `sprite_x` = 430, direction left, `bounce_cnt` +1, `hit` = 1. After 15 ticks `hit` = 0 and motion resumes.
- **Corner bounce:** `sprite_x` = 429, `sprite_y` = 171, right/down → 430/172, `bounce_cnt` +2. Separately, 255 + 1 wraps to 0.
- **Tear-free deferral (macro on):** three ticks while `y` = 100 → no change. `y` → 272 → exactly one step applied the next cycle.
- **Key conflicts:** `key[0]` edge coincident with an applied move → no move, PAUSE. `key[2]` edge coincident with a move → the move goes left.
